// File: rtl/iq_pkg.sv
// iq_pkg: shared field positions, widths, sync defaults and lock FSM encoding for the I/Q unpacker.
package iq_pkg;
   localparam logic [1:0] I_SYNC_DEF = 2'b10;
   localparam logic [1:0] Q_SYNC_DEF = 2'b01;
   localparam int I_SYNC_MSB = 31;
   localparam int Q_SYNC_MSB = 15;
   localparam int I_MSB      = 29;
   localparam int I_CTL      = 16;
   localparam int Q_MSB      = 13;
   localparam int MARK       = 0;
   localparam int SAMP_W     = 13;
   localparam int OUT_W      = 16;
   localparam int ENTRY_W    = 2 * OUT_W + 1;

   typedef enum logic {HUNT, LOCKED} lock_state_t;

   function automatic logic [OUT_W-1:0] sext(input logic [SAMP_W-1:0] x);
      return {{(OUT_W - SAMP_W){x[SAMP_W-1]}}, x};
   endfunction
endpackage

// File: rtl/iq_sample_fifo.sv
// iq_sample_fifo: synchronous sample FIFO; pointers carry one extra wrap bit so count spans 0..DEPTH.
module iq_sample_fifo
   import iq_pkg::*;
#(
   parameter int WIDTH = ENTRY_W,
   parameter int DEPTH = 4
) (
   input  logic                       i_ddr_clk,
   input  logic                       i_rst_b,
   input  logic                       wr_en,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       rd_en,
   output logic [WIDTH-1:0]           rd_data,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;

   // pointer advance; only the pointers are cleared, stale storage is unreachable once empty
   always_ff @(posedge i_ddr_clk or negedge i_rst_b)
      if (!i_rst_b) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + (AW + 1)'(1);
         if (rd_en) rd_ptr <= rd_ptr + (AW + 1)'(1);
      end

   // storage write
   always_ff @(posedge i_ddr_clk)
      if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;

   assign rd_data = mem[rd_ptr[AW-1:0]];
   assign count   = wr_ptr - rd_ptr;
endmodule

// File: rtl/iq_word_unpacker.sv
// iq_word_unpacker: checks sync fields, tracks link lock, sign-extends I/Q and buffers samples.
// Define IQ_STATS_EN to build the saturating o_sync_err / o_drop_cnt counters; otherwise they read 0.
module iq_word_unpacker
   import iq_pkg::*;
#(
   parameter logic [1:0] I_SYNC     = I_SYNC_DEF,
   parameter logic [1:0] Q_SYNC     = Q_SYNC_DEF,
   parameter int         DEPTH      = 4,
   parameter int         LOCK_CNT   = 4,
   parameter int         UNLOCK_CNT = 2
) (
   input  logic        i_ddr_clk,
   input  logic        i_rst_b,
   input  logic        i_word_valid,
   input  logic [31:0] i_word,
   output logic        o_full,
   output logic        o_valid,
   input  logic        i_ready,
   output logic [15:0] o_i,
   output logic [15:0] o_q,
   output logic        o_mark,
   output logic        o_locked,
   output logic [15:0] o_sync_err,
   output logic [15:0] o_drop_cnt
);
   localparam int          AW       = $clog2(DEPTH);
   localparam logic [AW:0] FULL     = (AW + 1)'(DEPTH);
   localparam logic [AW:0] FULL_M1  = (AW + 1)'(DEPTH - 1);
   localparam logic [3:0]  LOCK_N   = 4'(LOCK_CNT);
   localparam logic [3:0]  UNLOCK_N = 4'(UNLOCK_CNT);

   logic [31:0]        w1;
   logic               v1;
   logic               good;
   lock_state_t        state, state_nx;
   logic [3:0]         run, run_nx;
   logic               wr_req, wr_en, pop, full_now;
   logic [AW:0]        count, count_nx;
   logic [ENTRY_W-1:0] rd_data;
   logic               unused_ctl;

   // stage 1: every clock captures the word together with its strobe
   always_ff @(posedge i_ddr_clk or negedge i_rst_b)
      if (!i_rst_b) begin
         w1 <= '0;
         v1 <= 1'b0;
      end else begin
         w1 <= i_word;
         v1 <= i_word_valid;
      end

   assign good       = (w1[I_SYNC_MSB -: 2] == I_SYNC) && (w1[Q_SYNC_MSB -: 2] == Q_SYNC);
   assign unused_ctl = w1[I_CTL];

   // lock FSM register
   always_ff @(posedge i_ddr_clk or negedge i_rst_b)
      if (!i_rst_b) begin
         state <= HUNT;
         run   <= '0;
      end else begin
         state <= state_nx;
         run   <= run_nx;
      end

   // run counts words pointing toward the other state; reaching the threshold flips state
   always_comb begin
      state_nx = state;
      run_nx   = run;
      if (v1) begin
         run_nx = (good == (state == HUNT)) ? run + 4'd1 : 4'd0;
         if (run_nx == ((state == HUNT) ? LOCK_N : UNLOCK_N)) begin
            state_nx = (state == HUNT) ? LOCKED : HUNT;
            run_nx   = 4'd0;
         end
      end
   end

   assign o_locked = (state == LOCKED);
   assign wr_req   = v1 && good && (state == LOCKED);
   assign o_valid  = (count != '0);
   assign pop      = o_valid && i_ready;
   assign full_now = (count == FULL);
   assign wr_en    = wr_req && (!full_now || pop);
   assign count_nx = count + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, pop};

   // back-pressure asserts one entry early so a word already in flight still fits
   always_ff @(posedge i_ddr_clk or negedge i_rst_b)
      if (!i_rst_b) o_full <= 1'b0;
      else          o_full <= (count_nx >= FULL_M1);

   iq_sample_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
      .i_ddr_clk (i_ddr_clk),
      .i_rst_b   (i_rst_b),
      .wr_en     (wr_en),
      .wr_data   ({w1[MARK], sext(w1[Q_MSB -: SAMP_W]), sext(w1[I_MSB -: SAMP_W])}),
      .rd_en     (pop),
      .rd_data   (rd_data),
      .count     (count)
   );

   assign o_i    = o_valid ? rd_data[OUT_W-1:0]       : '0;
   assign o_q    = o_valid ? rd_data[2*OUT_W-1:OUT_W] : '0;
   assign o_mark = o_valid && rd_data[2*OUT_W];

`ifdef IQ_STATS_EN
   logic drop;
   assign drop = wr_req && full_now && !pop;

   // saturating sync-error and drop counters
   always_ff @(posedge i_ddr_clk or negedge i_rst_b)
      if (!i_rst_b) begin
         o_sync_err <= '0;
         o_drop_cnt <= '0;
      end else begin
         if (v1 && !good && o_sync_err != 16'hFFFF) o_sync_err <= o_sync_err + 16'd1;
         if (drop && o_drop_cnt != 16'hFFFF)        o_drop_cnt <= o_drop_cnt + 16'd1;
      end
`else
   assign o_sync_err = '0;
   assign o_drop_cnt = '0;
`endif
endmodule

// File: tb/tb_iq_word_unpacker.sv
// tb_iq_word_unpacker: scoreboard bench for the I/Q unpacker; stats expectations follow IQ_STATS_EN.
module tb_iq_word_unpacker;
`ifdef IQ_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_b = 1'b0;
   logic        i_word_valid = 1'b0;
   logic [31:0] i_word = '0;
   logic        i_ready = 1'b0;
   logic        o_full, o_valid, o_mark, o_locked;
   logic [15:0] o_i, o_q, o_sync_err, o_drop_cnt;

   int          total = 0;
   int          bad = 0;
   logic [32:0] exp_q[$];

   always #5 clk = ~clk;

   iq_word_unpacker dut (
      .i_ddr_clk    (clk),
      .i_rst_b      (rst_b),
      .i_word_valid (i_word_valid),
      .i_word       (i_word),
      .o_full       (o_full),
      .o_valid      (o_valid),
      .i_ready      (i_ready),
      .o_i          (o_i),
      .o_q          (o_q),
      .o_mark       (o_mark),
      .o_locked     (o_locked),
      .o_sync_err   (o_sync_err),
      .o_drop_cnt   (o_drop_cnt)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] sx(input logic [12:0] x);
      return {{3{x[12]}}, x};
   endfunction

   function automatic logic [31:0] mk(input logic [1:0] is, input logic [12:0] iv,
                                      input logic [12:0] qv, input logic m);
      return {is, iv, 1'b0, 2'b01, qv, m};
   endfunction

   task automatic expect_word(input logic [31:0] w);
      exp_q.push_back({w[0], sx(w[13:1]), sx(w[29:17])});
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive(input logic [31:0] w, input bit wr);
      i_word_valid = 1'b1;
      i_word = w;
      if (wr) expect_word(w);
      idle(1);
      i_word_valid = 1'b0;
   endtask

   task automatic drain();
      i_ready = 1'b1;
      for (int c = 0; c < 60 && (exp_q.size() != 0 || o_valid); c++) idle(1);
      chk("drain_q", exp_q.size(), 0);
      chk("drain_valid", o_valid, 0);
   endtask

   // each transfer the DUT is about to make is compared with the oldest expected sample
   always @(negedge clk)
      if (rst_b && o_valid && i_ready) begin
         if (exp_q.size() == 0) chk("sb_nonempty", exp_q.size(), 1);
         else chk("sample", {o_mark, o_q, o_i}, exp_q.pop_front());
      end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int sent;
      logic [31:0] w;
      #1;
      chk("rst_valid", o_valid, 0);
      chk("rst_full", o_full, 0);
      chk("rst_locked", o_locked, 0);
      chk("rst_err", o_sync_err, 0);
      chk("rst_drop", o_drop_cnt, 0);
      chk("rst_i", o_i, 0);
      #11 rst_b = 1'b1;
      idle(1);

      // 1: hunt with interruptions, lock on the 4th good word, first written word is the next one
      i_ready = 1'b1;
      drive(mk(2'b00, 13'h1, 13'h1, 1'b0), 1'b0);
      drive(mk(2'b10, 13'h0FFF, 13'h1000, 1'b0), 1'b0);
      drive(mk(2'b10, 13'h0FFF, 13'h1000, 1'b0), 1'b0);
      drive(mk(2'b11, 13'h2, 13'h2, 1'b0), 1'b0);
      for (int j = 0; j < 3; j++) drive(mk(2'b10, 13'h0FFF, 13'h1000, 1'b0), 1'b0);
      idle(2);
      chk("hunt_3good", o_locked, 0);
      drive(mk(2'b10, 13'h0FFF, 13'h1000, 1'b0), 1'b0);
      idle(1);
      chk("lock_4good", o_locked, 1);
      chk("lock_word_unwritten", o_valid, 0);
      chk("err_in_hunt", o_sync_err, STATS ? 2 : 0);
      drive(mk(2'b10, 13'h0FFF, 13'h1000, 1'b1), 1'b1);
      chk("lat_n1", o_valid, 0);
      idle(1);
      chk("lat_n2", o_valid, 1);
      chk("t1_i", o_i, 16'h0FFF);
      chk("t1_q", o_q, 16'hF000);
      chk("t1_mark", o_mark, 1);
      drain();

      // 2: two bad words unlock; nothing written
      drive(mk(2'b00, 13'h5, 13'h5, 1'b0), 1'b0);
      idle(1);
      chk("unlock_1bad", o_locked, 1);
      drive(mk(2'b00, 13'h6, 13'h6, 1'b0), 1'b0);
      idle(1);
      chk("unlock_2bad", o_locked, 0);
      chk("err_locked", o_sync_err, STATS ? 4 : 0);
      chk("bad_unwritten", o_valid, 0);

      // 3: relock, sink stalled, six words ignoring o_full: four stored, two dropped
      for (int j = 0; j < 4; j++) drive(mk(2'b10, 13'h7, 13'h7, 1'b0), 1'b0);
      idle(1);
      chk("relock", o_locked, 1);
      i_ready = 1'b0;
      for (int j = 0; j < 6; j++) begin
         drive(mk(2'b10, 13'(j + 1), 13'(13'h1F00 + j), j[0]), j < 4);
         if (j == 2) chk("full_after2", o_full, 0);
         if (j == 3) chk("full_after3", o_full, 1);
      end
      idle(2);
      chk("drop_cnt", o_drop_cnt, STATS ? 2 : 0);
      chk("full_held", o_full, 1);
      chk("hold_i", o_i, 16'h0001);
      chk("hold_q", o_q, 16'hFF00);
      drain();
      chk("full_clear", o_full, 0);

      // 4: fill, then send only while o_full is low with the sink toggling
      i_ready = 1'b0;
      for (int j = 0; j < 4; j++) drive(mk(2'b10, 13'(13'h100 + j), 13'(13'h1800 + j), 1'b1), 1'b1);
      idle(2);
      chk("t4_full", o_full, 1);
      sent = 0;
      for (int c = 0; c < 200 && sent < 8; c++) begin
         i_ready = ~i_ready;
         if (!o_full) begin
            w = mk(2'b10, 13'(13'h200 + sent), 13'(13'h0A0 + sent), sent[0]);
            i_word_valid = 1'b1;
            i_word = w;
            expect_word(w);
            sent++;
         end
         idle(1);
         i_word_valid = 1'b0;
      end
      chk("t4_sent", sent, 8);
      drain();
      chk("t4_no_drop", o_drop_cnt, STATS ? 2 : 0);

      // 5: asynchronous reset with samples pending
      i_ready = 1'b0;
      drive(mk(2'b10, 13'h300, 13'h301, 1'b0), 1'b1);
      drive(mk(2'b10, 13'h302, 13'h303, 1'b1), 1'b1);
      idle(2);
      chk("t5_pending", o_valid, 1);
      #2 rst_b = 1'b0;
      #1;
      chk("arst_valid", o_valid, 0);
      chk("arst_locked", o_locked, 0);
      chk("arst_full", o_full, 0);
      chk("arst_err", o_sync_err, 0);
      chk("arst_drop", o_drop_cnt, 0);
      exp_q.delete();
      @(posedge clk);
      #3 rst_b = 1'b1;
      idle(1);
      for (int j = 0; j < 3; j++) drive(mk(2'b10, 13'h8, 13'h8, 1'b0), 1'b0);
      idle(1);
      chk("relock_needed", o_locked, 0);
      drive(mk(2'b10, 13'h8, 13'h8, 1'b0), 1'b0);
      idle(1);
      chk("relock_done", o_locked, 1);
      drive(mk(2'b10, 13'h1ABC, 13'h0123, 1'b1), 1'b1);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
